// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetches over a req/ack instruction port, drives an
// external Hack ALU, and performs data reads/writes over a separate req/ack port.
module hack_cpu_ctrl #(
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic [15:0] instret
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM_RD = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM_WR = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] m_latch_q;
    logic [DATA_W-1:0] wb_latch_q;
    logic [ADDR_W-1:0] waddr_q;

    logic              fetch_done;
    logic              decode_a;
    logic              rd_done;
    logic              exec_en;
    logic              wr_done;
    logic              jump_c;
    logic [ADDR_W-1:0] pc_inc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!instr_q[15]) begin
                    state_d = S_FETCH;
                end else if (instr_q[12]) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEM_RD: begin
                if (dmem_ack) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (instr_q[3]) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (dmem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: port requests and datapath update strobes straight from state
    always_comb begin
        imem_req   = 1'b0;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        dmem_addr  = a_reg[ADDR_W-1:0];
        fetch_done = 1'b0;
        decode_a   = 1'b0;
        rd_done    = 1'b0;
        exec_en    = 1'b0;
        wr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req   = 1'b1;
                fetch_done = imem_ack;
            end
            S_DECODE: begin
                decode_a = ~instr_q[15];
            end
            S_MEM_RD: begin
                dmem_rd = 1'b1;
                rd_done = dmem_ack;
            end
            S_EXEC: begin
                exec_en = 1'b1;
            end
            S_MEM_WR: begin
                dmem_wr   = 1'b1;
                dmem_addr = waddr_q;
                wr_done   = dmem_ack;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // Jump condition and sequential PC
    always_comb begin
        jump_c = (instr_q[2] & alu_ng)
               | (instr_q[1] & alu_zr)
               | (instr_q[0] & ~alu_zr & ~alu_ng);
        pc_inc = ADDR_W'(pc + ADDR_W'(1));
    end

    assign imem_addr  = pc;
    assign dmem_wdata = wb_latch_q;

    // ALU operands and controls follow the held instruction at all times
    assign alu_x  = d_reg;
    assign alu_y  = instr_q[12] ? m_latch_q : a_reg;
    assign alu_zx = instr_q[11];
    assign alu_nx = instr_q[10];
    assign alu_zy = instr_q[9];
    assign alu_ny = instr_q[8];
    assign alu_f  = instr_q[7];
    assign alu_no = instr_q[6];

    // Instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
        end else if (fetch_done) begin
            instr_q <= imem_data;
        end
    end

    // M latch holds the value read for a C-instruction with a=1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_latch_q <= '0;
        end else if (rd_done) begin
            m_latch_q <= dmem_rdata;
        end
    end

    // Write data and address captured in EXEC; address uses A before its update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_latch_q <= '0;
            waddr_q    <= '0;
        end else if (exec_en) begin
            wb_latch_q <= alu_out;
            waddr_q    <= a_reg[ADDR_W-1:0];
        end
    end

    // A register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
        end else if (decode_a) begin
            a_reg <= {1'b0, instr_q[14:0]};
        end else if (exec_en && instr_q[5]) begin
            a_reg <= alu_out;
        end
    end

    // D register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg <= '0;
        end else if (exec_en && instr_q[4]) begin
            d_reg <= alu_out;
        end
    end

    // Program counter; jump target is A before this cycle's writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (decode_a) begin
            pc <= pc_inc;
        end else if (exec_en) begin
            pc <= jump_c ? a_reg[ADDR_W-1:0] : pc_inc;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (decode_a || wr_done || (exec_en && !instr_q[3])) begin
            instret <= DATA_W'(instret + DATA_W'(1));
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl with a Hack ALU model and req/ack memory responders.
module tb_hack_cpu_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] instret;

    int checks;
    int errors;

    logic        imem_en;
    int          dmem_delay;
    int          dcnt;
    int          dmem_cycles;
    int          wr_cycles;
    int          wr_bad;
    logic [14:0] exp_wr_addr;
    logic [15:0] exp_wr_data;
    logic [14:0] last_wr_addr;
    logic [15:0] last_wr_data;
    logic [14:0] last_rd_addr;
    int          rd_count;

    hack_cpu_ctrl #(.RESET_PC(15'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hack ALU reference
    logic [15:0] ax, ay, ar;
    always_comb begin
        ax = alu_zx ? 16'h0000 : alu_x;
        if (alu_nx) ax = ~ax;
        ay = alu_zy ? 16'h0000 : alu_y;
        if (alu_ny) ay = ~ay;
        ar = alu_f ? 16'(ax + ay) : (ax & ay);
        if (alu_no) ar = ~ar;
    end
    assign alu_out = ar;
    assign alu_zr  = (ar == 16'h0000);
    assign alu_ng  = ar[15];

    assign imem_ack = imem_req & imem_en;
    assign dmem_ack = (dmem_rd | dmem_wr) && (dcnt == dmem_delay);

    // Data-port wait-state counter and activity monitor
    always @(posedge clk) begin
        if (rst) begin
            dcnt <= 0;
        end else if ((dmem_rd | dmem_wr) && !dmem_ack) begin
            dcnt <= dcnt + 1;
        end else begin
            dcnt <= 0;
        end
        if (!rst && (dmem_rd | dmem_wr)) dmem_cycles <= dmem_cycles + 1;
        if (!rst && dmem_wr) begin
            wr_cycles <= wr_cycles + 1;
            if (dmem_addr !== exp_wr_addr || dmem_wdata !== exp_wr_data) wr_bad <= wr_bad + 1;
            if (dmem_ack) begin
                last_wr_addr <= dmem_addr;
                last_wr_data <= dmem_wdata;
            end
        end
        if (!rst && dmem_rd && dmem_ack) begin
            last_rd_addr <= dmem_addr;
            rd_count     <= rd_count + 1;
        end
    end

    // Fetch one instruction, return its latency in cycles and the fetch address
    task automatic run_instr(input logic [15:0] ins, output int cyc, output logic [14:0] faddr);
        int n;
        n = 0;
        cyc = -1;
        faddr = '0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            checks++; errors++;
            $display("FAIL fetch_wait instr=%h imem_req never rose", ins);
            return;
        end
        faddr = imem_addr;
        imem_data = ins;
        imem_en = 1'b1;
        @(negedge clk);
        imem_en = 1'b0;
        cyc = 1;
        while (!imem_req && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!imem_req) begin
            checks++; errors++;
            $display("FAIL retire_wait instr=%h no next fetch within %0d cycles", ins, cyc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, dmem_rd, dmem_wr} !== 3'b000) begin
            errors++; $display("FAIL reset_req got=%b exp=000", {imem_req, dmem_rd, dmem_wr});
        end
        checks++;
        if (pc !== 15'h0000 || a_reg !== 16'h0 || d_reg !== 16'h0 || instret !== 16'h0) begin
            errors++; $display("FAIL reset_regs pc=%h a=%h d=%h ir=%h exp all zero", pc, a_reg, d_reg, instret);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin
            errors++; $display("FAIL reset_first_fetch req=%b addr=%h exp 1/0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_a_instr;
        int c; logic [14:0] fa;
        run_instr(16'h0005, c, fa);
        checks++;
        if (c !== 2 || a_reg !== 16'h0005 || pc !== 15'h0001 || instret !== 16'd1) begin
            errors++; $display("FAIL a_instr cyc=%0d a=%h pc=%h ir=%0d exp 2/0005/0001/1", c, a_reg, pc, instret);
        end
    endtask

    task automatic test_d_eq_a;
        int c, d0; logic [14:0] fa;
        d0 = dmem_cycles;
        run_instr(16'hEC10, c, fa);
        checks++;
        if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b110000) begin
            errors++; $display("FAIL d_eq_a_ctrl got=%b exp=110000", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
        end
        checks++;
        if (c !== 3 || d_reg !== 16'h0005 || pc !== 15'h0002 || instret !== 16'd2) begin
            errors++; $display("FAIL d_eq_a cyc=%0d d=%h pc=%h ir=%0d exp 3/0005/0002/2", c, d_reg, pc, instret);
        end
        checks++;
        if (dmem_cycles !== d0) begin
            errors++; $display("FAIL d_eq_a_nomem dmem cycles=%0d exp 0", dmem_cycles - d0);
        end
    endtask

    task automatic test_mem_write_wait;
        int c, w0; logic [14:0] fa;
        run_instr(16'h0010, c, fa);
        exp_wr_addr = 15'h0010;
        exp_wr_data = 16'h0006;
        dmem_delay = 3;
        w0 = wr_cycles;
        wr_bad = 0;
        run_instr(16'hE7C8, c, fa);
        dmem_delay = 0;
        checks++;
        if (wr_cycles - w0 !== 4 || wr_bad !== 0) begin
            errors++; $display("FAIL mwr_hold cycles=%0d unstable=%0d exp 4/0", wr_cycles - w0, wr_bad);
        end
        checks++;
        if (last_wr_addr !== 15'h0010 || last_wr_data !== 16'h0006) begin
            errors++; $display("FAIL mwr_data addr=%h data=%h exp 0010/0006", last_wr_addr, last_wr_data);
        end
        checks++;
        if (c !== 7 || instret !== 16'd4 || pc !== 15'h0004 || d_reg !== 16'h0005) begin
            errors++; $display("FAIL mwr_retire cyc=%0d ir=%0d pc=%h d=%h exp 7/4/0004/0005", c, instret, pc, d_reg);
        end
    endtask

    task automatic test_read_modify_write;
        int c, r0; logic [14:0] fa;
        run_instr(16'h0020, c, fa);
        dmem_rdata = 16'h0000;
        exp_wr_addr = 15'h0020;
        exp_wr_data = 16'hFFFF;
        wr_bad = 0;
        r0 = rd_count;
        run_instr(16'hFCA8, c, fa);
        checks++;
        if (rd_count - r0 !== 1 || last_rd_addr !== 15'h0020) begin
            errors++; $display("FAIL rmw_read count=%0d addr=%h exp 1/0020", rd_count - r0, last_rd_addr);
        end
        checks++;
        if (last_wr_addr !== 15'h0020 || last_wr_data !== 16'hFFFF || wr_bad !== 0) begin
            errors++; $display("FAIL rmw_write addr=%h data=%h bad=%0d exp 0020/ffff/0", last_wr_addr, last_wr_data, wr_bad);
        end
        checks++;
        if (c !== 5 || a_reg !== 16'hFFFF || pc !== 15'h0006 || instret !== 16'd6) begin
            errors++; $display("FAIL rmw_regs cyc=%0d a=%h pc=%h ir=%0d exp 5/ffff/0006/6", c, a_reg, pc, instret);
        end
    endtask

    task automatic test_jumps;
        int c; logic [14:0] fa;
        run_instr(16'h0100, c, fa);
        run_instr(16'hEA87, c, fa);
        checks++;
        if (pc !== 15'h0100 || instret !== 16'd8) begin
            errors++; $display("FAIL jmp_uncond pc=%h ir=%0d exp 0100/8", pc, instret);
        end
        run_instr(16'hEA90, c, fa);
        run_instr(16'hE304, c, fa);
        checks++;
        if (alu_zr !== 1'b1 || pc !== 15'h0102 || d_reg !== 16'h0000) begin
            errors++; $display("FAIL jlt_not_taken zr=%b pc=%h d=%h exp 1/0102/0000", alu_zr, pc, d_reg);
        end
        run_instr(16'h7FFF, c, fa);
        run_instr(16'hEC10, c, fa);
        run_instr(16'hE7D0, c, fa);
        checks++;
        if (d_reg !== 16'h8000 || pc !== 15'h0105) begin
            errors++; $display("FAIL d_inc d=%h pc=%h exp 8000/0105", d_reg, pc);
        end
        run_instr(16'hE304, c, fa);
        checks++;
        if (pc !== 15'h7FFF || instret !== 16'd14) begin
            errors++; $display("FAIL jlt_taken pc=%h ir=%0d exp 7fff/14", pc, instret);
        end
    endtask

    task automatic test_pc_wrap;
        int c; logic [14:0] fa;
        run_instr(16'h0005, c, fa);
        checks++;
        if (fa !== 15'h7FFF || pc !== 15'h0000 || a_reg !== 16'h0005 || instret !== 16'd15) begin
            errors++; $display("FAIL pc_wrap fetch=%h pc=%h a=%h ir=%0d exp 7fff/0000/0005/15", fa, pc, a_reg, instret);
        end
    endtask

    task automatic test_reset_in_fetch;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL pre_reset_fetch req=%b exp 1", imem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || a_reg !== 16'h0 || d_reg !== 16'h0 || pc !== 15'h0 || instret !== 16'h0) begin
            errors++; $display("FAIL async_reset req=%b a=%h d=%h pc=%h ir=%h exp 0/0/0/0/0", imem_req, a_reg, d_reg, pc, instret);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin
            errors++; $display("FAIL post_reset_fetch req=%b addr=%h exp 1/0000", imem_req, imem_addr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        imem_en = 1'b0;
        imem_data = 16'h0000;
        dmem_rdata = 16'h0000;
        dmem_delay = 0;
        dmem_cycles = 0;
        wr_cycles = 0;
        wr_bad = 0;
        rd_count = 0;
        exp_wr_addr = '0;
        exp_wr_data = '0;
        last_wr_addr = '0;
        last_wr_data = '0;
        last_rd_addr = '0;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_a_instr();
        test_d_eq_a();
        test_mem_write_wait();
        test_read_modify_write();
        test_jumps();
        test_pc_wrap();
        test_reset_in_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
